// File: rtl/macro_lane_gather_pkg.sv
// Shared definitions for the lane gather block and its helpers.
// State encoding, safe index-width helper and the lane pad value.
package macro_lane_gather_pkg;

    // FILL collects words; HOLD presents a finished frame.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Unfilled lanes read as all ones so AND/NAND reductions
    // downstream see their identity value.
    localparam bit PAD = 1'b1;

    // Width of a lane index, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/macro_lane_gather_if.sv
// Stream-in / frame-out bundle for macro_lane_gather.
// slave: the gatherer; master: the producer/consumer around it.
interface macro_lane_gather_if
    import macro_lane_gather_pkg::*;
#(
    parameter int INPUT_WIDTH = 1,
    parameter int INPUT_COUNT = 1
);

    logic                               s_valid;
    logic                               s_ready;
    logic [INPUT_WIDTH-1:0]             s_data;
    logic                               s_last;
    logic                               m_valid;
    logic                               m_ready;
    logic [INPUT_WIDTH*INPUT_COUNT-1:0] m_data;
    logic [INPUT_COUNT-1:0]             m_mask;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_mask
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_mask
    );

endinterface

// File: rtl/macro_lane_gather_onehot_decoder.sv
// Lane index to one-hot write enable, gated by en.
// Ports: idx (lane index), en (write strobe), onehot (per-lane enable).
module macro_onehot_decoder
    import macro_lane_gather_pkg::*;
#(
    parameter int COUNT = 1,
    parameter int IDX_W = idx_width(COUNT)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < COUNT; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/macro_lane_gather.sv
// Serial-to-packed lane gatherer: INPUT_COUNT words -> one frame.
// Ports: clk, reset (sync, active-high), bus (slave modport:
// s_valid/s_ready/s_data/s_last in, m_valid/m_ready/m_data/m_mask out).
// Option: MACRO_LANE_GATHER_BYPASS_EN lets a new beat enter while the
// held frame is being consumed, giving one word per cycle.
module macro_lane_gather
    import macro_lane_gather_pkg::*;
#(
    parameter int INPUT_WIDTH = 1,
    parameter int INPUT_COUNT = 1
) (
    input  logic                clk,
    input  logic                reset,
    macro_lane_gather_if.slave  bus
);

    localparam int FW = INPUT_WIDTH * INPUT_COUNT;
    localparam int IW = idx_width(INPUT_COUNT);
    localparam logic [IW-1:0] LAST_IDX = IW'(INPUT_COUNT - 1);

    state_t                 state;
    state_t                 state_nx;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_nx;
    logic [FW-1:0]          data_q;
    logic [FW-1:0]          data_nx;
    logic [INPUT_COUNT-1:0] mask_q;
    logic [INPUT_COUNT-1:0] mask_nx;

    logic                   accept;
    logic [IW-1:0]          wr_idx;
    logic [INPUT_COUNT-1:0] wen;

`ifdef MACRO_LANE_GATHER_BYPASS_EN
    localparam bit SINGLE = (INPUT_COUNT == 1);

    // A held frame leaving this cycle frees the block for a new beat.
    assign bus.s_ready = !reset &&
                         ((state == FILL) || bus.m_ready);
`else
    assign bus.s_ready = !reset && (state == FILL);
`endif

    assign accept = bus.s_valid && bus.s_ready;

    // A beat accepted in HOLD starts a fresh frame at lane 0.
    assign wr_idx = (state == HOLD) ? '0 : idx;

    macro_onehot_decoder #(
        .COUNT (INPUT_COUNT),
        .IDX_W (IW)
    ) u_dec (
        .idx    (wr_idx),
        .en     (accept),
        .onehot (wen)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        data_nx  = data_q;
        mask_nx  = mask_q;
        unique case (state)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < INPUT_COUNT; i++) begin
                        if (wen[i]) begin
                            data_nx[i*INPUT_WIDTH +: INPUT_WIDTH] = bus.s_data;
                        end
                    end
                    mask_nx = mask_q | wen;
                    if ((idx == LAST_IDX) || bus.s_last) begin
                        state_nx = HOLD;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    data_nx  = {FW{PAD}};
                    mask_nx  = '0;
                    state_nx = FILL;
                    idx_nx   = '0;
`ifdef MACRO_LANE_GATHER_BYPASS_EN
                    if (accept) begin
                        data_nx[INPUT_WIDTH-1:0] = bus.s_data;
                        mask_nx = wen;
                        if (bus.s_last || SINGLE) begin
                            state_nx = HOLD;
                        end else begin
                            idx_nx = IW'(1);
                        end
                    end
`endif
                end
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FILL;
            idx    <= '0;
            data_q <= {FW{PAD}};
            mask_q <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            data_q <= data_nx;
            mask_q <= mask_nx;
        end
    end

    // Frame outputs come straight from registers.
    assign bus.m_valid = (state == HOLD);
    assign bus.m_data  = data_q;
    assign bus.m_mask  = mask_q;

endmodule
